c2h_frame_arbiter: RTL and testbench
====================================

// Module: c2h_frame_arbiter
// PURPOSE
//  Round-robin scheduler sharing the single C2H AXI-stream frame writer between NUM_SRC producers.
//  Captures one DATA_W frame from the granted source and issues it to the writer with a 1-cycle data_valid.
//  Waits for the writer's data_next completion pulse, then rotates priority.
//  Watchdog aborts a stalled writer (host not draining tready) and flags the offending source.
// PARAMETERS
//  NUM_SRC      4      number of frame producers (2..8)
//  SRC_W        2      width of source index, clog2(NUM_SRC)
//  DATA_W       4072   frame width, matches the writer's data input
//  TIMEOUT_CYC  1024   max cycles in WAIT before abort (1..65535)
//  ABORT_CYC    2      cycles wr_abort is held high during abort
// PORTS
//  m_axis_c2h_aclk     in   1               clock
//  m_axis_c2h_aresetn  in   1               asynchronous active-low reset
//  soft_clr            in   1               synchronous clear, active high
//  src_valid           in   NUM_SRC         bit i: source i has a frame ready (level, held until src_ack)
//  src_data            in   NUM_SRC*DATA_W  source i frame at [i*DATA_W +: DATA_W]
//  src_ack             out  NUM_SRC         1-cycle pulse: frame of source i captured
//  wr_data_valid       out  1               to writer data_valid, 1-cycle pulse per frame
//  wr_data             out  DATA_W          to writer data, registered
//  wr_data_next        in   1               writer completion pulse (last beat accepted)
//  wr_abort            out  1               to writer en (its synchronous clear)
//  busy                out  1               state != IDLE
//  cur_src             out  SRC_W           index of source owning the writer
//  frame_cnt           out  32              completed frames, wraps 2^32-1 -> 0
//  err_timeout         out  1               sticky: watchdog fired
//  err_src             out  SRC_W           source index at first timeout
// BEHAVIOUR
//  Reset (aresetn=0, async): state=IDLE; all outputs 0; rr_ptr=NUM_SRC-1 (src 0 wins first); counters 0.
//  soft_clr=1: same values as reset, applied at clock edge; wr_abort=1 while soft_clr high; overrides all else.
//  States: IDLE=0, ISSUE=1, WAIT=2, GAP=3, ABORT=4.
//  IDLE: if |src_valid: winner = first set bit searching rr_ptr+1, rr_ptr+2.. mod NUM_SRC;
//    register wr_data<=src_data[winner], cur_src<=winner, rr_ptr<=winner; -> ISSUE.
//  ISSUE (one cycle): wr_data_valid=1, src_ack[cur_src]=1, wd_cnt<=0; -> WAIT.
//    Latency: src_valid sampled high at edge N -> wr_data_valid/src_ack high in cycle N+1.
//  WAIT: wr_data_valid=0; wr_data held stable; wd_cnt++ each cycle.
//    wr_data_next=1 -> frame_cnt++, -> GAP.
//    else wd_cnt==TIMEOUT_CYC-1 -> -> ABORT; err_timeout<=1; err_src<=cur_src only if err_timeout was 0.
//    wr_data_next and timeout same cycle: completion wins, no error.
//  GAP (one cycle): lets writer return to its idle state; no issue; -> IDLE.
//  ABORT: wr_abort=1 for ABORT_CYC cycles, frame not counted, -> IDLE; rr_ptr already advanced past cur_src.
//  wr_data_next seen outside WAIT: ignored (no count, no state change).
//  src_valid dropping after grant: no effect, frame already captured.
//  Min issue period: ISSUE+WAIT+GAP+IDLE; back-to-back frames never overlap writer ownership.
//  Priority rotation: after serving i, i is lowest priority; a continuously valid source can't starve others.
//  err_timeout/err_src cleared only by reset or soft_clr.
//  All outputs registered; no combinational path from inputs to outputs.
// TESTING
//  1 Only src_valid[2]=1, writer pulses data_next 20 cycles after issue -> one src_ack[2], wr_data==frame2, frame_cnt=1.
//  2 src_valid=4'b1111 held, acks re-presented -> grant order 0,1,2,3,0,1; exactly one wr_data_valid per ISSUE.
//  3 Writer never pulses data_next, TIMEOUT_CYC=16 -> ABORT 16 cycles after ISSUE, wr_abort 2 cycles, err_timeout=1, err_src=cur_src, frame_cnt unchanged.
//  4 data_next on the exact timeout cycle -> GAP, frame_cnt++, err_timeout stays 0.
//  5 aresetn low mid-WAIT then soft_clr mid-ISSUE -> all outputs 0 immediately (async) / next edge; next grant goes to src 0.
//  6 frame_cnt preloaded via force to 32'hFFFF_FFFF, one completion -> frame_cnt=0.

Source files
------------

// File: rtl/c2h_frame_arbiter.sv
// Round-robin scheduler that lends the single C2H frame writer to one of NUM_SRC producers at a time.
// It captures a frame, issues it, waits for completion or a watchdog abort, then rotates priority.
`timescale 1ns/1ps
module c2h_frame_arbiter #(
   parameter int unsigned NUM_SRC     = 4,
   parameter int unsigned SRC_W       = 2,
   parameter int unsigned DATA_W      = 4072,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned ABORT_CYC   = 2
) (
   input  logic                      m_axis_c2h_aclk,
   input  logic                      m_axis_c2h_aresetn,
   input  logic                      soft_clr,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   output logic [NUM_SRC-1:0]        src_ack,
   output logic                      wr_data_valid,
   output logic [DATA_W-1:0]         wr_data,
   input  logic                      wr_data_next,
   output logic                      wr_abort,
   output logic                      busy,
   output logic [SRC_W-1:0]          cur_src,
   output logic [31:0]               frame_cnt,
   output logic                      err_timeout,
   output logic [SRC_W-1:0]          err_src
);

   localparam int unsigned WD_W = 16;
   localparam int unsigned AB_W = (ABORT_CYC > 1) ? $clog2(ABORT_CYC) : 1;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StIssue = 3'd1,
      StWait  = 3'd2,
      StGap   = 3'd3,
      StAbort = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [SRC_W-1:0]    rr_q, rr_d;
   logic [SRC_W-1:0]    cur_q, cur_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [NUM_SRC-1:0]  ack_q, ack_d;
   logic                valid_q, valid_d;
   logic                abort_q, abort_d;
   logic                busy_q, busy_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [AB_W-1:0]     ab_q, ab_d;
   logic [31:0]         frame_cnt_q, frame_cnt_d;
   logic                err_t_q, err_t_d;
   logic [SRC_W-1:0]    err_s_q, err_s_d;

   logic                found;
   logic [SRC_W-1:0]    winner;
   logic [DATA_W-1:0]   win_data;
   int unsigned         idx;

   // Search starts just after the last served source, so that source ends up lowest priority.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int unsigned i = 1; i <= NUM_SRC; i++) begin
         idx = (32'(rr_q) + i) % NUM_SRC;
         if (!found && src_valid[SRC_W'(idx)]) begin
            found  = 1'b1;
            winner = SRC_W'(idx);
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (winner == SRC_W'(i)) win_data = src_data[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      cur_d       = cur_q;
      data_d      = data_q;
      ack_d       = '0;
      valid_d     = 1'b0;
      abort_d     = 1'b0;
      wd_d        = wd_q;
      ab_d        = ab_q;
      frame_cnt_d = frame_cnt_q;
      err_t_d     = err_t_q;
      err_s_d     = err_s_q;

      unique case (state_q)
         StIdle: begin
            if (found) begin
               data_d  = win_data;
               cur_d   = winner;
               rr_d    = winner;
               valid_d = 1'b1;
               ack_d   = NUM_SRC'(1) << winner;
               state_d = StIssue;
            end
         end
         StIssue: begin
            wd_d    = '0;
            state_d = StWait;
         end
         StWait: begin
            // Completion takes precedence over a coincident timeout.
            if (wr_data_next) begin
               frame_cnt_d = frame_cnt_q + 32'd1;
               state_d     = StGap;
            end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
               state_d = StAbort;
               abort_d = 1'b1;
               ab_d    = '0;
               err_t_d = 1'b1;
               if (!err_t_q) err_s_d = cur_q;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         StGap: begin
            state_d = StIdle;
         end
         StAbort: begin
            if (ab_q == AB_W'(ABORT_CYC - 1)) begin
               state_d = StIdle;
            end else begin
               ab_d    = ab_q + AB_W'(1);
               abort_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (soft_clr) begin
         state_d     = StIdle;
         rr_d        = SRC_W'(NUM_SRC - 1);
         cur_d       = '0;
         data_d      = '0;
         ack_d       = '0;
         valid_d     = 1'b0;
         abort_d     = 1'b1;
         wd_d        = '0;
         ab_d        = '0;
         frame_cnt_d = '0;
         err_t_d     = 1'b0;
         err_s_d     = '0;
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
      if (!m_axis_c2h_aresetn) begin
         state_q     <= StIdle;
         rr_q        <= SRC_W'(NUM_SRC - 1);
         cur_q       <= '0;
         data_q      <= '0;
         ack_q       <= '0;
         valid_q     <= 1'b0;
         abort_q     <= 1'b0;
         busy_q      <= 1'b0;
         wd_q        <= '0;
         ab_q        <= '0;
         frame_cnt_q <= '0;
         err_t_q     <= 1'b0;
         err_s_q     <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         cur_q       <= cur_d;
         data_q      <= data_d;
         ack_q       <= ack_d;
         valid_q     <= valid_d;
         abort_q     <= abort_d;
         busy_q      <= busy_d;
         wd_q        <= wd_d;
         ab_q        <= ab_d;
         frame_cnt_q <= frame_cnt_d;
         err_t_q     <= err_t_d;
         err_s_q     <= err_s_d;
      end
   end

   assign src_ack       = ack_q;
   assign wr_data_valid = valid_q;
   assign wr_data       = data_q;
   assign wr_abort      = abort_q;
   assign busy          = busy_q;
   assign cur_src       = cur_q;
   assign frame_cnt     = frame_cnt_q;
   assign err_timeout   = err_t_q;
   assign err_src       = err_s_q;

endmodule

// File: tb/tb_c2h_frame_arbiter.sv
// Directed bench for c2h_frame_arbiter: grant order, completion, watchdog abort, resets, counter wrap.
`timescale 1ns/1ps
module tb_c2h_frame_arbiter;

   localparam int unsigned NUM_SRC     = 4;
   localparam int unsigned SRC_W       = 2;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned TIMEOUT_CYC = 16;
   localparam int unsigned ABORT_CYC   = 2;

   logic                      clk = 1'b0;
   logic                      aresetn;
   logic                      soft_clr;
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic [NUM_SRC-1:0]        src_ack;
   logic                      wr_data_valid;
   logic [DATA_W-1:0]         wr_data;
   logic                      wr_data_next;
   logic                      wr_abort;
   logic                      busy;
   logic [SRC_W-1:0]          cur_src;
   logic [31:0]               frame_cnt;
   logic                      err_timeout;
   logic [SRC_W-1:0]          err_src;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   c2h_frame_arbiter #(
      .NUM_SRC    (NUM_SRC),
      .SRC_W      (SRC_W),
      .DATA_W     (DATA_W),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .ABORT_CYC  (ABORT_CYC)
   ) dut (
      .m_axis_c2h_aclk   (clk),
      .m_axis_c2h_aresetn(aresetn),
      .soft_clr          (soft_clr),
      .src_valid         (src_valid),
      .src_data          (src_data),
      .src_ack           (src_ack),
      .wr_data_valid     (wr_data_valid),
      .wr_data           (wr_data),
      .wr_data_next      (wr_data_next),
      .wr_abort          (wr_abort),
      .busy              (busy),
      .cur_src           (cur_src),
      .frame_cnt         (frame_cnt),
      .err_timeout       (err_timeout),
      .err_src           (err_src)
   );

   function automatic logic [31:0] frame(input int s);
      case (s)
         0:       return 32'hA0A0_A0A0;
         1:       return 32'hB1B1_B1B1;
         2:       return 32'hC2C2_C2C2;
         default: return 32'hD3D3_D3D3;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cleared(input string tag, input logic abort_exp);
      chk({tag, "_busy"},  64'(busy), 64'd0);
      chk({tag, "_valid"}, 64'(wr_data_valid), 64'd0);
      chk({tag, "_ack"},   64'(src_ack), 64'd0);
      chk({tag, "_data"},  64'(wr_data), 64'd0);
      chk({tag, "_cur"},   64'(cur_src), 64'd0);
      chk({tag, "_cnt"},   64'(frame_cnt), 64'd0);
      chk({tag, "_errt"},  64'(err_timeout), 64'd0);
      chk({tag, "_errs"},  64'(err_src), 64'd0);
      chk({tag, "_abort"}, 64'(wr_abort), 64'(abort_exp));
   endtask

   // Entered in an IDLE cycle with src_valid already set; returns in the next IDLE cycle.
   task automatic run_frame(input int src, input int waits, input logic [31:0] cnt_exp,
                            input bit drop);
      logic [3:0] ack_exp;
      ack_exp = 4'b0001 << src;
      tick();
      chk("issue_valid", 64'(wr_data_valid), 64'd1);
      chk("issue_ack",   64'(src_ack), 64'(ack_exp));
      chk("issue_cur",   64'(cur_src), 64'(src));
      chk("issue_data",  64'(wr_data), 64'(frame(src)));
      chk("issue_busy",  64'(busy), 64'd1);
      if (drop) src_valid[2'(src)] = 1'b0;
      tick();
      chk("wait_valid",  64'(wr_data_valid), 64'd0);
      chk("wait_ack",    64'(src_ack), 64'd0);
      repeat (waits - 1) tick();
      wr_data_next = 1'b1;
      tick();
      wr_data_next = 1'b0;
      chk("gap_cnt",     64'(frame_cnt), 64'(cnt_exp));
      chk("gap_data",    64'(wr_data), 64'(frame(src)));
      chk("gap_busy",    64'(busy), 64'd1);
      chk("gap_abort",   64'(wr_abort), 64'd0);
      tick();
      chk("idle_busy",   64'(busy), 64'd0);
      chk("idle_valid",  64'(wr_data_valid), 64'd0);
   endtask

   task automatic run_abort(input int src, input logic [31:0] cnt_exp, input int err_src_exp);
      tick();
      chk("ab_issue_cur", 64'(cur_src), 64'(src));
      src_valid[2'(src)] = 1'b0;
      repeat (TIMEOUT_CYC) tick();
      chk("ab_pre_abort", 64'(wr_abort), 64'd0);
      chk("ab_pre_busy",  64'(busy), 64'd1);
      tick();
      chk("ab_abort1",    64'(wr_abort), 64'd1);
      chk("ab_errt",      64'(err_timeout), 64'd1);
      chk("ab_errs",      64'(err_src), 64'(err_src_exp));
      chk("ab_cnt",       64'(frame_cnt), 64'(cnt_exp));
      tick();
      chk("ab_abort2",    64'(wr_abort), 64'd1);
      tick();
      chk("ab_abort_end", 64'(wr_abort), 64'd0);
      chk("ab_idle_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      aresetn      = 1'b0;
      soft_clr     = 1'b0;
      src_valid    = '0;
      wr_data_next = 1'b0;
      src_data     = {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
      #12;
      check_cleared("reset", 1'b0);
      aresetn = 1'b1;
      tick();

      // All sources held valid: rotation starting at source 0.
      src_valid = 4'b1111;
      run_frame(0, 2, 32'd1, 1'b0);
      run_frame(1, 2, 32'd2, 1'b0);
      run_frame(2, 2, 32'd3, 1'b0);
      run_frame(3, 2, 32'd4, 1'b0);
      run_frame(0, 2, 32'd5, 1'b0);
      run_frame(1, 2, 32'd6, 1'b0);
      src_valid = '0;

      // Single source 2, completion after 10 wait cycles.
      src_valid = 4'b0100;
      run_frame(2, 10, 32'd7, 1'b1);

      // Completion pulse while idle is ignored.
      wr_data_next = 1'b1;
      tick();
      wr_data_next = 1'b0;
      tick();
      chk("stray_next_cnt",  64'(frame_cnt), 64'd7);
      chk("stray_next_busy", 64'(busy), 64'd0);

      // Completion on the exact timeout cycle wins.
      src_valid = 4'b1000;
      run_frame(3, TIMEOUT_CYC, 32'd8, 1'b1);
      chk("edge_errt", 64'(err_timeout), 64'd0);

      // Watchdog abort, then a second abort must not overwrite err_src.
      src_valid = 4'b0010;
      run_abort(1, 32'd8, 1);
      src_valid = 4'b0100;
      run_abort(2, 32'd8, 1);

      // Async reset in the middle of WAIT.
      src_valid = 4'b0001;
      tick();
      chk("pre_rst_cur", 64'(cur_src), 64'd0);
      src_valid = '0;
      repeat (4) tick();
      aresetn = 1'b0;
      #2;
      check_cleared("async_rst", 1'b0);
      #2;
      aresetn = 1'b1;
      tick();

      // Soft clear during ISSUE.
      src_valid = 4'b0100;
      tick();
      chk("pre_clr_valid", 64'(wr_data_valid), 64'd1);
      chk("pre_clr_cur",   64'(cur_src), 64'd2);
      soft_clr  = 1'b1;
      src_valid = '0;
      tick();
      check_cleared("soft_clr", 1'b1);
      soft_clr = 1'b0;
      tick();
      chk("post_clr_abort", 64'(wr_abort), 64'd0);
      src_valid = 4'b1111;
      run_frame(0, 2, 32'd1, 1'b0);
      src_valid = '0;

      // Frame counter wraps.
      force dut.frame_cnt_q = 32'hFFFF_FFFF;
      tick();
      tick();
      release dut.frame_cnt_q;
      #1;
      chk("wrap_preload", 64'(frame_cnt), 64'hFFFF_FFFF);
      src_valid = 4'b0001;
      run_frame(0, 3, 32'd0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
